// File: rtl/dcim_bitserial_ctrl.sv
// dcim_bitserial_ctrl: bit-serial activation sequencer and shift-accumulator for one local_mac
module dcim_bitserial_ctrl #(
    parameter int ACT_BITS = 8,
    localparam int ACC_W = 16 + ACT_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*ACT_BITS-1:0]   act_row0,
    input  logic [8*ACT_BITS-1:0]   act_row1,
    input  logic                    act_signed,
    input  logic                    w_signed,
    output logic [7:0]              rwlb_row0,
    output logic [7:0]              rwlb_row1,
    output logic                    sus,
    input  logic [14:0]             mac_in,
    output logic [ACC_W-1:0]        result,
    output logic                    result_valid,
    input  logic                    result_ready
);
    localparam int BW = (ACT_BITS > 1) ? $clog2(ACT_BITS) : 1;
    localparam logic [BW-1:0] TOP = BW'(ACT_BITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                        r_state, w_next;
    logic [7:0][ACT_BITS-1:0]      r_act0, r_act1, w_src0, w_src1;
    logic                          r_act_signed, r_sus, r_valid;
    logic [BW-1:0]                 r_bit, w_sel;
    logic [ACC_W-1:0]              r_acc, r_result, w_pp, w_acc_next;
    logic [7:0]                    r_rwlb0, r_rwlb1, w_plane0, w_plane1;
    logic                          w_accept, w_last;

    assign w_accept     = in_valid && (r_state == IDLE);
    assign w_last       = (r_state == RUN) && (r_bit == '0);
    assign w_src0       = (r_state == IDLE) ? act_row0 : r_act0;
    assign w_src1       = (r_state == IDLE) ? act_row1 : r_act1;
    assign w_pp         = r_sus ? {{(ACC_W-15){mac_in[14]}}, mac_in} : {{(ACC_W-15){1'b0}}, mac_in};
    assign w_acc_next   = (r_bit == TOP && r_act_signed) ? (r_acc << 1) - w_pp : (r_acc << 1) + w_pp;
    assign in_ready     = (r_state == IDLE);
    assign rwlb_row0    = r_rwlb0;
    assign rwlb_row1    = r_rwlb1;
    assign sus          = r_sus;
    assign result       = r_result;
    assign result_valid = r_valid;

    // Next bit plane: MSB straight from the inputs on accept, otherwise plane b-1 of the captured rows
    always_comb begin
        w_sel = (r_state == IDLE) ? TOP : r_bit - 1'b1;
        for (int i = 0; i < 8; i++) begin
            w_plane0[i] = w_src0[i][w_sel];
            w_plane1[i] = w_src1[i][w_sel];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state: one RUN cycle per bit plane, DONE holds until the consumer takes the result
    always_comb begin
        w_next = r_state;
        if (w_accept)                              w_next = RUN;
        else if (w_last)                           w_next = DONE;
        else if (r_state == DONE && result_ready)  w_next = IDLE;
    end

    // Capture, wordline drive, MSB-first shift-accumulate and result hand-off
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act0       <= '0;
            r_act1       <= '0;
            r_act_signed <= 1'b0;
            r_sus        <= 1'b0;
            r_bit        <= '0;
            r_acc        <= '0;
            r_result     <= '0;
            r_valid      <= 1'b0;
            r_rwlb0      <= '0;
            r_rwlb1      <= '0;
        end else if (w_accept) begin
            r_act0       <= act_row0;
            r_act1       <= act_row1;
            r_act_signed <= act_signed;
            r_sus        <= w_signed;
            r_bit        <= TOP;
            r_acc        <= '0;
            r_rwlb0      <= w_plane0;
            r_rwlb1      <= w_plane1;
        end else if (r_state == RUN) begin
            r_acc <= w_acc_next;
            if (w_last) begin
                r_result <= w_acc_next;
                r_valid  <= 1'b1;
                r_rwlb0  <= '0;
                r_rwlb1  <= '0;
            end else begin
                r_bit   <= r_bit - 1'b1;
                r_rwlb0 <= w_plane0;
                r_rwlb1 <= w_plane1;
            end
        end else if (r_state == DONE && result_ready) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dcim_bitserial_ctrl.sv
// tb_dcim_bitserial_ctrl: directed and random jobs against a behavioural macro, scoreboarded results
module tb_dcim_bitserial_ctrl;
    logic        clk = 1'b0;
    logic        rst, in_valid, act_signed, w_signed, result_ready;
    logic [63:0] act_row0, act_row1;
    logic        in_ready, sus, result_valid;
    logic [7:0]  rwlb_row0, rwlb_row1;
    logic [14:0] mac_in;
    logic [23:0] result;
    logic [7:0]  wt [16];
    logic [23:0] q [$];
    logic [23:0] e;
    int          ms;
    int          n_assert = 0;
    int          n_fail = 0;

    dcim_bitserial_ctrl #(.ACT_BITS(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .act_row0(act_row0), .act_row1(act_row1), .act_signed(act_signed), .w_signed(w_signed),
        .rwlb_row0(rwlb_row0), .rwlb_row1(rwlb_row1), .sus(sus), .mac_in(mac_in),
        .result(result), .result_valid(result_valid), .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    // Behavioural macro: sum of weights on active wordlines, weights signed when sus
    always_comb begin
        ms = 0;
        for (int i = 0; i < 8; i++) begin
            if (rwlb_row0[i]) ms += sus ? int'($signed(wt[i]))   : int'(wt[i]);
            if (rwlb_row1[i]) ms += sus ? int'($signed(wt[i+8])) : int'(wt[i+8]);
        end
        mac_in = 15'(ms);
    end

    function automatic int ev(logic [7:0] v, logic sg);
        return sg ? int'($signed(v)) : int'(v);
    endfunction

    function automatic logic [23:0] ref_dot(logic [63:0] a0, logic [63:0] a1, logic as, logic ws);
        int s = 0;
        for (int i = 0; i < 8; i++) begin
            s += ev(a0[i*8 +: 8], as) * ev(wt[i], ws);
            s += ev(a1[i*8 +: 8], as) * ev(wt[i+8], ws);
        end
        return 24'(s);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(logic [63:0] a0, logic [63:0] a1, logic as, logic ws, logic [23:0] exp);
        act_row0 = a0; act_row1 = a1; act_signed = as; w_signed = ws; in_valid = 1'b1;
        q.push_back(exp);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(string tag);
        int n = 0;
        while (!result_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " result_valid timeout"}, 32'(result_valid), 1);
        if (result_ready) tick();
    endtask

    // Scoreboard: every accepted result must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && result_valid && result_ready) begin
            chk("sb expectation pending", 32'(q.size() > 0), 1);
            if (q.size() > 0) chk("sb result", 32'(result), 32'(q.pop_front()));
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; result_ready = 1'b1;
        act_row0 = '0; act_row1 = '0; act_signed = 1'b0; w_signed = 1'b0;
        for (int i = 0; i < 16; i++) wt[i] = 8'd1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("reset in_ready", 32'(in_ready), 1);
        chk("reset rwlb0", 32'(rwlb_row0), 0);
        chk("reset rwlb1", 32'(rwlb_row1), 0);
        chk("reset result_valid", 32'(result_valid), 0);
        chk("reset result", 32'(result), 0);

        start_job({8{8'h03}}, 64'h0, 1'b0, 1'b0, 24'd24);
        for (int k = 0; k < 8; k++) begin
            chk("unsigned rwlb0 plane", 32'(rwlb_row0), (k >= 6) ? 32'hFF : 32'h0);
            chk("unsigned rwlb1 plane", 32'(rwlb_row1), 0);
            chk("unsigned valid low in RUN", 32'(result_valid), 0);
            tick();
        end
        chk("unsigned valid at T+9", 32'(result_valid), 1);
        tick();
        chk("unsigned valid one cycle", 32'(result_valid), 0);
        chk("unsigned back to idle", 32'(in_ready), 1);

        start_job({8{8'hFF}}, {8{8'hFF}}, 1'b1, 1'b0, 24'hFFFFF0);
        wait_done("signed");
        start_job({8{8'hFF}}, {8{8'hFF}}, 1'b0, 1'b0, 24'd4080);
        wait_done("unsigned ff");

        result_ready = 1'b0;
        start_job({8{8'h05}}, {8{8'h07}}, 1'b0, 1'b0, 24'd96);
        wait_done("backpressure");
        for (int i = 0; i < 10; i++) begin
            chk("bp result stable", 32'(result), 32'd96);
            chk("bp result_valid held", 32'(result_valid), 1);
            chk("bp in_ready low", 32'(in_ready), 0);
            chk("bp rwlb0 idle", 32'(rwlb_row0), 0);
            if (i == 3) begin
                act_row0 = {8{8'h01}}; act_row1 = 64'h0; act_signed = 1'b0; in_valid = 1'b1;
            end
            tick();
        end
        result_ready = 1'b1;
        tick();
        chk("bp release idle", 32'(in_ready), 1);
        q.push_back(24'd8);
        tick();
        in_valid = 1'b0;
        chk("bp second accepted", 32'(in_ready), 0);
        wait_done("bp second");

        act_row0 = {8{8'h03}}; act_row1 = {8{8'h03}}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun rst in_ready", 32'(in_ready), 1);
        chk("midrun rst rwlb0", 32'(rwlb_row0), 0);
        chk("midrun rst rwlb1", 32'(rwlb_row1), 0);
        chk("midrun rst result", 32'(result), 0);
        for (int i = 0; i < 12; i++) begin
            chk("midrun no valid pulse", 32'(result_valid), 0);
            tick();
        end
        start_job({8{8'h01}}, {8{8'h01}}, 1'b0, 1'b0, 24'd16);
        wait_done("after reset");

        for (int j = 0; j < 200; j++) begin
            logic [63:0] a0, a1;
            logic as, ws;
            for (int i = 0; i < 16; i++) wt[i] = 8'($urandom);
            a0 = {$urandom, $urandom};
            a1 = {$urandom, $urandom};
            as = 1'($urandom_range(0, 1));
            ws = 1'($urandom_range(0, 1));
            e = ref_dot(a0, a1, as, ws);
            start_job(a0, a1, as, ws, e);
            act_row0 = {$urandom, $urandom}; act_row1 = {$urandom, $urandom};
            act_signed = ~as; w_signed = ~ws;
            wait_done("random");
        end

        chk("sb drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
